// File: rtl/smvm_row_collector_pkg.sv
// SMVM row collector shared definitions.
// Widths match the SMVM datapath constants.
package smvm_row_collector_pkg;

  localparam int SMVM_PSUM_W = 18;
  localparam int SMVM_OUT_W  = 24;
  localparam int SMVM_ROW_W  = 8;
  localparam int SMVM_DEPTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/smvm_result_fifo.sv
// Row result FIFO with a registered head word.
// Head keeps its last value while the FIFO is empty.
module smvm_result_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [W-1:0]  head_q, head_d;

  // Next pointers and the word that will sit at the head next cycle
  always_comb begin
    wr_d = push_i ? wr_q + PW'(1) : wr_q;
    rd_d = pop_i  ? rd_q + PW'(1) : rd_q;
    head_d = mem_q[rd_d[AW-1:0]];
    if (push_i && (wr_q[AW-1:0] == rd_d[AW-1:0]))
      head_d = din_i;
  end

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = head_q;

  // Storage array, written on every push
  always_ff @(posedge clk) begin
    if (push_i)
      mem_q[wr_q[AW-1:0]] <= din_i;
  end

  // Pointers and registered head word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (wr_d != rd_d)
        head_q <= head_d;
    end
  end

endmodule

// File: rtl/smvm_row_collector.sv
// Accumulates signed partial sums per row and emits row results
// in order through a small result FIFO.
module smvm_row_collector
  import smvm_row_collector_pkg::*;
#(
  parameter int PSUM_W = SMVM_PSUM_W,
  parameter int OUT_W  = SMVM_OUT_W,
  parameter int DEPTH  = SMVM_DEPTH,
  parameter int ROW_W  = SMVM_ROW_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [PSUM_W-1:0] psum_data,
  input  logic              psum_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  data_out,
  output logic              busy,
  output logic              done
);

  state_e             state_q;
  logic [ROW_W-1:0]   nrows_q;
  logic [ROW_W-1:0]   rows_in_q;
  logic [ROW_W-1:0]   rows_out_q;
  logic [OUT_W-1:0]   acc_q;
  logic [OUT_W-1:0]   sum;
  logic               accept;
  logic               pop;
  logic               push;
  logic               last_row;
  logic               last_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_clr;

  // Handshakes, row sum and end-of-matrix detection
  always_comb begin
    sum = acc_q +
      {{(OUT_W-PSUM_W){psum_data[PSUM_W-1]}}, psum_data};
    pop = !fifo_empty && out_ready;
    psum_ready = (state_q == ST_RUN) && (!fifo_full || pop);
    accept = psum_valid && psum_ready;
    push = accept && psum_last;
    last_row = (rows_in_q + ROW_W'(1)) == nrows_q;
    last_pop = (state_q == ST_DRAIN) && pop &&
               ((rows_out_q + ROW_W'(1)) == nrows_q);
    fifo_clr = (state_q == ST_IDLE) && start;
  end

  assign out_valid = !fifo_empty;
  assign busy      = (state_q != ST_IDLE);
  assign done      = last_pop;

  // Matrix FSM with accumulator and row counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      nrows_q    <= '0;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      acc_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            nrows_q    <= num_rows;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            acc_q      <= '0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (psum_last) begin
              acc_q     <= '0;
              rows_in_q <= rows_in_q + ROW_W'(1);
              if (last_row)
                state_q <= ST_DRAIN;
            end else begin
              acc_q <= sum;
            end
          end
          if (pop)
            rows_out_q <= rows_out_q + ROW_W'(1);
        end
        ST_DRAIN: begin
          if (pop) begin
            rows_out_q <= rows_out_q + ROW_W'(1);
            if (last_pop)
              state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  smvm_result_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (fifo_clr),
    .push_i  (push),
    .din_i   (sum),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (data_out)
  );

endmodule

// File: tb/tb_smvm_row_collector.sv
// Randomized bench for smvm_row_collector against a
// row-sum reference model.
module tb_smvm_row_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  num_rows;
  logic        psum_valid;
  logic        psum_ready;
  logic [17:0] psum_data;
  logic        psum_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] data_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic signed [17:0] ps_d[$];
  bit                 ps_l[$];
  logic [23:0]        exp_q[$];
  logic [23:0]        got_q[$];

  int          r_done_cnt, r_done_bad, r_timeout, r_lat;
  int          r_rows_pre, r_rows_post;
  logic        r_rdy_pre, r_rdy_at, r_rdy_post, r_ov_post;
  logic        r_busy_after, r_ov_after;
  logic [23:0] r_dout_after;

  smvm_row_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_rows   (num_rows),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_data  (psum_data),
    .psum_last  (psum_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference: each row result is the plain sum of its psums mod 2^24
  function automatic void build_exp();
    int acc;
    logic [23:0] v;
    acc = 0;
    exp_q.delete();
    foreach (ps_d[i]) begin
      acc += int'(ps_d[i]);
      if (ps_l[i]) begin
        v = acc[23:0];
        exp_q.push_back(v);
        acc = 0;
      end
    end
  endfunction

  task automatic add_psum(input logic signed [17:0] d, input bit l);
    ps_d.push_back(d);
    ps_l.push_back(l);
  endtask

  task automatic add_rand_row(input int extra);
    logic signed [17:0] x;
    for (int k = 0; k < extra; k++) begin
      x = 18'($urandom);
      add_psum(x, 1'b0);
    end
    x = 18'($urandom);
    add_psum(x, 1'b1);
  endtask

  task automatic run_matrix(input int nrows, input int vld_pct,
                            input int rdy_pct, input int hold,
                            input int gap, input int mid_start);
    int idx, cyc, pops, rows_acc, first_last, first_valid;
    bit pend, acc;
    bit exp_done;
    idx = 0; cyc = 0; pops = 0; rows_acc = 0;
    first_last = -1; first_valid = -1; pend = 0;
    r_done_cnt = 0; r_done_bad = 0;
    r_rows_pre = -1; r_rows_post = -1;
    r_rdy_pre = 1'bx; r_rdy_at = 1'bx;
    r_rdy_post = 1'bx; r_ov_post = 1'bx;
    got_q.delete();
    build_exp();
    @(negedge clk);
    start = 1'b1;
    num_rows = 8'(nrows);
    @(negedge clk);
    start = 1'b0;
    num_rows = 8'hAA;
    while (pops < nrows && cyc < 3000) begin
      if (!pend) begin
        if (idx < ps_d.size() && $urandom_range(99) < vld_pct) begin
          psum_valid = 1'b1;
          psum_data = ps_d[idx];
          psum_last = ps_l[idx];
        end else begin
          psum_valid = 1'b0;
        end
      end
      if (cyc < hold) out_ready = 1'b0;
      else if (cyc == hold) out_ready = 1'b1;
      else if (cyc <= hold + gap) out_ready = 1'b0;
      else out_ready = ($urandom_range(99) < rdy_pct);
      start = (cyc == mid_start);
      num_rows = (cyc == mid_start) ? 8'd7 : 8'hAA;
      #1;
      if (cyc == hold - 1) begin
        r_rdy_pre = psum_ready;
        r_rows_pre = rows_acc;
      end
      if (cyc == hold) r_rdy_at = psum_ready;
      if (cyc == hold + 1) begin
        r_rdy_post = psum_ready;
        r_rows_post = rows_acc;
        r_ov_post = out_valid;
      end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      exp_done = out_valid && out_ready && (pops == nrows - 1);
      if (done !== exp_done) r_done_bad++;
      if (done === 1'b1) r_done_cnt++;
      if (out_valid === 1'b1 && out_ready) begin
        got_q.push_back(data_out);
        checks++;
        if (pops >= exp_q.size()) begin
          errors++;
          $display("FAIL extra_result got %h", data_out);
        end else if (data_out !== exp_q[pops]) begin
          errors++;
          $display("FAIL row_result %0d got %h exp %h",
                   pops, data_out, exp_q[pops]);
        end
        pops++;
      end
      acc = psum_valid && (psum_ready === 1'b1);
      if (acc) begin
        if (ps_l[idx]) begin
          rows_acc++;
          if (first_last < 0) first_last = cyc;
        end
        idx++;
      end
      pend = psum_valid && !acc;
      @(negedge clk);
      cyc++;
    end
    psum_valid = 1'b0;
    out_ready = 1'b0;
    start = 1'b0;
    #1;
    r_timeout = (cyc >= 3000);
    r_lat = first_valid - first_last;
    r_busy_after = busy;
    r_ov_after = out_valid;
    r_dout_after = data_out;
    checks++;
    if (r_timeout != 0 || pops != exp_q.size()) begin
      errors++;
      $display("FAIL result_count got %0d exp %0d", pops, exp_q.size());
    end
    checks++;
    if (r_done_cnt != 1 || r_done_bad != 0) begin
      errors++;
      $display("FAIL done_pulse got %0d pulses, %0d bad cycles exp 1, 0",
               r_done_cnt, r_done_bad);
    end
    checks++;
    if (r_busy_after !== 1'b0 || r_ov_after !== 1'b0) begin
      errors++;
      $display("FAIL idle_after busy=%b out_valid=%b exp 0 0",
               r_busy_after, r_ov_after);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    num_rows = '0;
    psum_valid = 1'b0;
    psum_data = '0;
    psum_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({psum_ready, out_valid, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000",
               {psum_ready, out_valid, busy, done});
    end
    checks++;
    if (data_out !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 000000", data_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    ps_d.delete(); ps_l.delete();
    add_psum(18'sd5, 1'b0);
    add_psum(18'sd7, 1'b1);
    add_psum(-18'sd3, 1'b1);
    run_matrix(2, 100, 100, 0, 0, -1);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 24'd12 ||
        got_q[1] !== 24'hFFFFFD) begin
      errors++;
      $display("FAIL basic_values got %p exp 12, -3", got_q);
    end
    checks++;
    if (r_lat != 1) begin
      errors++;
      $display("FAIL basic_latency got %0d exp 1", r_lat);
    end
    checks++;
    if (r_dout_after !== 24'hFFFFFD) begin
      errors++;
      $display("FAIL data_hold got %h exp fffffd", r_dout_after);
    end
  endtask

  task automatic test_sign();
    ps_d.delete(); ps_l.delete();
    add_psum(-18'sd131072, 1'b0);
    add_psum(-18'sd131072, 1'b0);
    add_psum(18'sd131071, 1'b1);
    run_matrix(1, 100, 100, 0, 0, -1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 24'hFDFFFF) begin
      errors++;
      $display("FAIL sign_ext got %p exp fdffff", got_q);
    end
  endtask

  task automatic test_backpressure();
    ps_d.delete(); ps_l.delete();
    for (int r = 0; r < 10; r++) add_rand_row(int'($urandom_range(2)));
    run_matrix(10, 100, 100, 40, 0, -1);
    checks++;
    if (r_rows_pre != 8 || r_rdy_pre !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall got rows=%0d ready=%b exp 8 0",
               r_rows_pre, r_rdy_pre);
    end
  endtask

  task automatic test_full_simul();
    ps_d.delete(); ps_l.delete();
    for (int r = 0; r < 12; r++) add_rand_row(0);
    run_matrix(12, 100, 100, 40, 5, -1);
    checks++;
    if (r_rows_pre != 8 || r_rdy_pre !== 1'b0 || r_rdy_at !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_ready got rows=%0d pre=%b at=%b exp 8 0 1",
               r_rows_pre, r_rdy_pre, r_rdy_at);
    end
    checks++;
    if (r_rows_post != 9 || r_rdy_post !== 1'b0 || r_ov_post !== 1'b1) begin
      errors++;
      $display("FAIL full_occupancy got rows=%0d ready=%b valid=%b exp 9 0 1",
               r_rows_post, r_rdy_post, r_ov_post);
    end
  endtask

  task automatic test_empty_start_ignore();
    ps_d.delete(); ps_l.delete();
    add_psum(18'sd0, 1'b1);
    add_psum(18'sd4, 1'b1);
    run_matrix(2, 100, 100, 0, 0, 1);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 24'd0 || got_q[1] !== 24'd4) begin
      errors++;
      $display("FAIL empty_row got %p exp 0, 4", got_q);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    num_rows = 8'd5;
    @(negedge clk);
    start = 1'b0;
    psum_valid = 1'b1;
    psum_last = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      psum_data = 18'(i + 1);
      @(negedge clk);
    end
    psum_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, psum_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid got valid/busy/ready=%b exp 000",
               {out_valid, busy, psum_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    ps_d.delete(); ps_l.delete();
    add_psum(18'sd9, 1'b1);
    run_matrix(1, 100, 100, 0, 0, -1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 24'd9) begin
      errors++;
      $display("FAIL reset_restart got %p exp 9", got_q);
    end
  endtask

  task automatic test_random();
    int n;
    for (int m = 0; m < 5; m++) begin
      ps_d.delete(); ps_l.delete();
      n = int'($urandom_range(20, 1));
      for (int r = 0; r < n; r++) begin
        if ($urandom_range(5) == 0) add_psum(18'sd0, 1'b1);
        else add_rand_row(int'($urandom_range(4)));
      end
      run_matrix(n, 60, 50, 0, 0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_backpressure();
    test_full_simul();
    test_empty_start_ignore();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
